audio_gain_ramp: RTL and testbench
==================================

AUDIO_GAIN_RAMP -- requirements
Module: audio_gain_ramp

Interface
REQ-001 SHALL have parameter width_p, default 24, signed sample width per channel.
REQ-002 SHALL have parameter gain_width_p, default 8, unsigned gain width.
REQ-003 SHALL have parameter step_p, default 8, target-gain change per up_i/down_i pulse.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  sole clock.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 valid_i  in  1  upstream (FIFO output) beat valid.
REQ-008 ready_o  out  1  this block accepts a beat.
REQ-009 data_i  in  2*width_p  {right, left}; right occupies the upper width_p bits.
REQ-010 valid_o  out  1  downstream (PISO input) beat valid.
REQ-011 ready_i  in  1  downstream accepts.
REQ-012 data_o  out  2*width_p  scaled {right, left}, same packing as data_i.
REQ-013 up_i  in  1  single-cycle pulse; raises target gain.
REQ-014 down_i  in  1  single-cycle pulse; lowers target gain.
REQ-015 gain_o  out  gain_width_p  current applied gain.
REQ-016 clip_o  out  1  high while the beat on data_o saturated in either channel.

Function
REQ-017 Gain format SHALL be unsigned Q2.6: 64 = unity, 255 = about 3.98x, 0 = mute.
REQ-018 Per channel: out = sat(floor((sample * gain) / 64)), computed as a signed width_p by zero-extended gain product followed by an arithmetic right shift of 6.
REQ-019 Saturation SHALL clamp to [-2^(width_p-1), 2^(width_p-1)-1].
REQ-020 Input handshake = valid_i & ready_o; output handshake = valid_o & ready_i.
REQ-021 Pipeline SHALL have 2 register stages: S1 holds the product and its gain, S2 holds the saturated result and clip flag.
REQ-022 Latency: an accepted beat SHALL appear on valid_o 2 cycles later when not stalled.
REQ-023 S2 SHALL load when it is empty or ready_i=1; S1 SHALL load when it is empty or S2 loads; ready_o = (S1 empty) | (S2 loads), combinational.
REQ-024 Under ready_i=0 the pipeline SHALL hold 2 beats, with no loss, duplication or reordering; data_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-025 Each input beat SHALL use gain_o as it was before that beat's handshake; one gain applies to both channels.
REQ-026 On each input handshake with gain_o != target, gain_o SHALL step 1 toward target. Without a handshake, gain_o SHALL hold.
REQ-027 up_i alone: target = min(target + step_p, 255). down_i alone: target = max(target - step_p, 0).
REQ-028 up_i and down_i in the same cycle SHALL leave target unchanged.
REQ-029 The target register SHALL update in the cycle after the pulse, independent of the handshake.
REQ-030 clip_o SHALL be registered alongside S2 and SHALL be 0 whenever valid_o=0.

Reset
REQ-031 Asynchronous reset SHALL immediately force valid_o=0, S1/S2 valid=0, data_o=0, clip_o=0, gain_o=64, target=64.
REQ-032 ready_o SHALL be 1 in the first cycle after reset is released.
REQ-033 Reset mid-stream SHALL discard any in-flight beats; none SHALL be emitted after release.

Structure
REQ-034 Package audio_pkg SHALL hold the constants gain_unity_c=64 and gain_frac_bits_c=6, and a stereo sample struct typedef {right, left}.
REQ-035 Sub-module gain_sat_lane (combinational: multiply, shift, saturate, clip flag) SHALL be instantiated twice, once per channel.
REQ-036 The block SHALL sit between the fifo_1r1w output and the piso input, replacing the direct FIFO-to-PISO connection.

Verification
REQ-037 After reset, ready_i=1, left=0x000100, right=0xFFFF00 -> 2 cycles later data_o={0xFFFF00,0x000100}, clip_o=0, gain_o=64.
REQ-038 Pulse up_i 8 times, then stream 64 beats -> gain_o climbs 65..128, one step per beat; at gain 128, left=0x000100 -> 0x000200.
REQ-039 At gain 128, left=0x600000 and right=0xA00000 -> data_o={0x800000,0x7FFFFF}, clip_o=1.
REQ-040 Continuous valid_i, ready_i=0 for 5 cycles -> ready_o=0 once 2 beats are held; after release all beats exit in order, with none dropped.
REQ-041 up_i and down_i in the same cycle -> target unchanged; 9 down_i pulses from reset -> target 0, gain ramps to 0, data_o=0.
REQ-042 Assert reset_i mid-stream with 2 beats in flight -> valid_o=0 the same cycle, gain_o=64, no stale beats after release.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and payload types for the audio gain ramp block.
//   gain_unity_c     : Q2.6 gain value for 1.0x
//   gain_frac_bits_c : fractional bits of the Q2.6 gain
//   stereo_t         : {right, left} sample pair, right in the upper half
package audio_pkg;

    localparam int unsigned gain_unity_c     = 64;
    localparam int unsigned gain_frac_bits_c = 6;
    localparam int unsigned sample_width_c   = 24;

    typedef struct packed {
        logic signed [sample_width_c-1:0] right;
        logic signed [sample_width_c-1:0] left;
    } stereo_t;

endpackage

// File: rtl/gain_sat_lane.sv
// One audio channel of the gain datapath (purely combinational).
// The multiply half feeds the S1 register; the shift/saturate half
// consumes the registered product and feeds S2.
//   sample_i    : signed input sample
//   gain_i      : unsigned Q2.6 gain
//   product_o   : sample_i * gain_i, full precision
//   product_q_i : product registered in S1
//   result_o    : floor(product / 64), clamped to the sample range
//   clip_o      : result_o was clamped
module gain_sat_lane
    import audio_pkg::*;
#(
    parameter int unsigned width_p      = 24,
    parameter int unsigned gain_width_p = 8
) (
    input  logic signed [width_p-1:0]            sample_i,
    input  logic        [gain_width_p-1:0]       gain_i,
    output logic signed [width_p+gain_width_p:0] product_o,
    input  logic signed [width_p+gain_width_p:0] product_q_i,
    output logic        [width_p-1:0]            result_o,
    output logic                                 clip_o
);

    localparam int unsigned prod_w = width_p + gain_width_p + 1;

    logic signed [prod_w-1:0] sample_ext;
    logic signed [prod_w-1:0] gain_ext;
    logic signed [prod_w-1:0] shifted;
    logic                     overflow;

    // Gain is zero-extended so the product stays a signed multiply.
    always_comb begin
        sample_ext = prod_w'(sample_i);
        gain_ext   = prod_w'({1'b0, gain_i});
        product_o  = sample_ext * gain_ext;
    end

    // Arithmetic shift gives floor division; any disagreement among the
    // bits above the sample's sign bit means the value is out of range.
    always_comb begin
        shifted  = product_q_i >>> gain_frac_bits_c;
        overflow = (shifted[prod_w-1:width_p-1] !=
                    {(prod_w-width_p+1){shifted[prod_w-1]}});
        result_o = shifted[width_p-1:0];
        if (overflow) begin
            result_o = shifted[prod_w-1] ? {1'b1, {(width_p-1){1'b0}}}
                                         : {1'b0, {(width_p-1){1'b1}}};
        end
        clip_o = overflow;
    end

endmodule

// File: rtl/audio_gain_ramp.sv
// Stereo gain stage with click-free ramping, placed between the
// fifo_1r1w output and the piso input. Two-stage pipeline: S1 holds the
// per-channel products, S2 the saturated samples and the clip flag.
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   valid_i/ready_o  : input handshake, data_i = {right, left}
//   valid_o/ready_i  : output handshake, data_o = {right, left} scaled
//   up_i/down_i      : pulses moving the target gain by step_p
//   gain_o           : gain currently applied to new beats (Q2.6)
//   clip_o           : the beat on data_o saturated in either channel
module audio_gain_ramp
    import audio_pkg::*;
#(
    parameter int unsigned width_p      = 24,
    parameter int unsigned gain_width_p = 8,
    parameter int unsigned step_p       = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [2*width_p-1:0]      data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [2*width_p-1:0]      data_o,
    input  logic                      up_i,
    input  logic                      down_i,
    output logic [gain_width_p-1:0]   gain_o,
    output logic                      clip_o
);

    localparam int unsigned              prod_w     = width_p + gain_width_p + 1;
    localparam logic [gain_width_p-1:0]  gain_max_c = '1;
    localparam logic [gain_width_p-1:0]  gain_rst_c = gain_width_p'(gain_unity_c);
    localparam logic [gain_width_p:0]    step_c     = (gain_width_p+1)'(step_p);

    logic [gain_width_p-1:0]  gain_q, gain_d;
    logic [gain_width_p-1:0]  target_q, target_d;
    logic [gain_width_p:0]    target_up;
    logic                     s1_valid_q, s2_valid_q;
    logic                     s1_load, s2_load, in_hs;
    logic signed [prod_w-1:0] prod_l, prod_r, prod_l_q, prod_r_q;
    logic [width_p-1:0]       res_l, res_r;
    logic                     clip_l, clip_r;

    gain_sat_lane #(.width_p(width_p), .gain_width_p(gain_width_p)) u_lane_left (
        .sample_i    ($signed(data_i[width_p-1:0])),
        .gain_i      (gain_q),
        .product_o   (prod_l),
        .product_q_i (prod_l_q),
        .result_o    (res_l),
        .clip_o      (clip_l)
    );

    gain_sat_lane #(.width_p(width_p), .gain_width_p(gain_width_p)) u_lane_right (
        .sample_i    ($signed(data_i[2*width_p-1:width_p])),
        .gain_i      (gain_q),
        .product_o   (prod_r),
        .product_q_i (prod_r_q),
        .result_o    (res_r),
        .clip_o      (clip_r)
    );

    // Elastic two-slot pipeline: a stage advances when the one after it can take data.
    always_comb begin
        s2_load = !s2_valid_q || ready_i;
        s1_load = !s1_valid_q || s2_load;
        ready_o = s1_load;
        in_hs   = valid_i && s1_load;
        valid_o = s2_valid_q;
        gain_o  = gain_q;
    end

    // Gain moves one LSB per accepted beat; target saturates at the gain range.
    always_comb begin
        gain_d    = gain_q;
        target_d  = target_q;
        target_up = {1'b0, target_q} + step_c;
        if (in_hs && (gain_q != target_q)) begin
            gain_d = (gain_q < target_q) ? gain_q + 1'b1 : gain_q - 1'b1;
        end
        if (up_i && !down_i) begin
            target_d = (target_up > {1'b0, gain_max_c}) ? gain_max_c
                                                        : target_up[gain_width_p-1:0];
        end else if (down_i && !up_i) begin
            target_d = ({1'b0, target_q} < step_c) ? '0
                                                   : target_q - step_c[gain_width_p-1:0];
        end
    end

    // Pipeline and gain state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gain_q     <= gain_rst_c;
            target_q   <= gain_rst_c;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_l_q   <= '0;
            prod_r_q   <= '0;
            data_o     <= '0;
            clip_o     <= 1'b0;
        end else begin
            gain_q   <= gain_d;
            target_q <= target_d;
            if (s1_load) begin
                s1_valid_q <= in_hs;
                if (in_hs) begin
                    prod_l_q <= prod_l;
                    prod_r_q <= prod_r;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                clip_o     <= s1_valid_q && (clip_l || clip_r);
                if (s1_valid_q) begin
                    data_o <= {res_r, res_l};
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Bench for audio_gain_ramp: directed stimulus, a behavioural scoreboard
// checked every cycle, and literal expectations for key beats.
module tb_audio_gain_ramp;
    import audio_pkg::*;

    localparam int unsigned W = 24;
    localparam int unsigned G = 8;

    logic           clk_i   = 1'b0;
    logic           reset_i = 1'b1;
    logic           valid_i = 1'b0;
    logic           ready_i = 1'b1;
    logic           up_i    = 1'b0;
    logic           down_i  = 1'b0;
    logic [2*W-1:0] data_i  = '0;
    logic           ready_o, valid_o, clip_o;
    logic [2*W-1:0] data_o;
    logic [G-1:0]   gain_o;

    audio_gain_ramp #(.width_p(W), .gain_width_p(G), .step_p(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .up_i    (up_i),
        .down_i  (down_i),
        .gain_o  (gain_o),
        .clip_o  (clip_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2*W-1:0] data;
        bit             clip;
        int             acc;
    } beat_t;

    beat_t q[$];
    int    gain_m, target_m, cyc;
    bit    m_ready, m_valid, m_pop, m_acc;

    function automatic void scale(input logic [W-1:0] s, input int g,
                                  output logic [W-1:0] r, output bit c);
        longint p, hi, lo;
        hi = (longint'(1) <<< (W-1)) - 1;
        lo = -(longint'(1) <<< (W-1));
        p  = (longint'($signed(s)) * g) >>> 6;
        c  = 1'b0;
        if (p > hi) begin r = W'(hi); c = 1'b1; end
        else if (p < lo) begin r = W'(lo); c = 1'b1; end
        else r = W'(p);
    endfunction

    always @(negedge clk_i) begin
        if (reset_i) begin
            q.delete();
            gain_m   = 64;
            target_m = 64;
            cyc      = 0;
            check("rst_valid", valid_o, 0);
            check("rst_gain", gain_o, 64);
            check("rst_clip", clip_o, 0);
        end else begin
            m_ready = !(q.size() == 2 && !ready_i);
            m_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
            check("ready", ready_o, m_ready);
            check("valid", valid_o, m_valid);
            check("gain", gain_o, gain_m);
            if (m_valid) begin
                check("data", data_o, q[0].data);
                check("clip", clip_o, q[0].clip);
            end else begin
                check("clip_idle", clip_o, 0);
            end
            m_pop = m_valid && ready_i;
            m_acc = valid_i && m_ready;
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                beat_t b;
                logic [W-1:0] rl, rr;
                bit cl, cr;
                scale(data_i[W-1:0], gain_m, rl, cl);
                scale(data_i[2*W-1:W], gain_m, rr, cr);
                b.data = {rr, rl};
                b.clip = cl | cr;
                b.acc  = cyc;
                q.push_back(b);
                if (gain_m < target_m) gain_m++;
                else if (gain_m > target_m) gain_m--;
            end
            if (up_i && !down_i) target_m = (target_m + 8 > 255) ? 255 : target_m + 8;
            else if (down_i && !up_i) target_m = (target_m < 8) ? 0 : target_m - 8;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [W-1:0] r, input logic [W-1:0] l);
        stereo_t s;
        bit acc;
        s.right = r;
        s.left  = l;
        data_i  = s;
        valid_i = 1'b1;
        acc     = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk_i);
            acc = ready_o;
            tick();
        end
        valid_i = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic pulse(input bit up, input bit down);
        up_i   = up;
        down_i = down;
        tick();
        up_i   = 1'b0;
        down_i = 1'b0;
        tick();
    endtask

    // Waits for the next output beat and pins it against literal values.
    task automatic expect_out(input string name, input logic [2*W-1:0] exp_d,
                              input bit exp_c, input int exp_lat);
        bit found;
        int n;
        found = 1'b0;
        n     = 0;
        while (!found && n < 20) begin
            @(negedge clk_i);
            n++;
            if (valid_o && ready_i) found = 1'b1;
        end
        check({name, "_seen"}, found, 1);
        if (found) begin
            check(name, data_o, exp_d);
            check({name, "_clip"}, clip_o, exp_c);
            if (exp_lat >= 0) check({name, "_latency"}, n, exp_lat);
        end
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  sent;
        bit  acc;

        reset_i = 1'b1;
        idle(3);
        @(negedge clk_i);
        check("rst_data", data_o, 0);
        tick();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_rst", ready_o, 1);
        tick();

        // Unity gain passes samples unchanged.
        send(24'hFFFF00, 24'h000100);
        expect_out("unity", {24'hFFFF00, 24'h000100}, 1'b0, 2);
        check("gain_unity", gain_o, 64);

        // Raise target to 128 and ramp one step per beat.
        repeat (8) pulse(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            if (i == 32) check("gain_mid", gain_o, 96);
            send(W'(-(i * 37 + 1)), 24'h000100);
        end
        idle(4);
        check("gain_128", gain_o, 128);
        send(24'h000000, 24'h000100);
        expect_out("gain_2x", {24'h000000, 24'h000200}, 1'b0, 2);

        // Saturation and the exact-boundary non-saturating case.
        send(24'hA00000, 24'h600000);
        expect_out("clip_sat", {24'h800000, 24'h7FFFFF}, 1'b1, 2);
        send(24'hC00000, 24'h3FFFFF);
        expect_out("edge_nosat", {24'h800000, 24'h7FFFFE}, 1'b0, 2);
        send(24'hFFFFFF, 24'h000001);
        expect_out("small", {24'hFFFFFE, 24'h000002}, 1'b0, 2);

        // Back-pressure: continuous valid, ready_i low for 5 cycles.
        sent    = 0;
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = {24'h000000, 24'h000010};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (c == 4) begin
                check("stall_ready", ready_o, 0);
                check("stall_valid", valid_o, 1);
                check("stall_head", data_o, {24'h000000, 24'h000020});
            end
            acc = ready_o;
            tick();
            if (acc) begin
                sent++;
                data_i = {24'h000000, W'(16 + sent)};
            end
        end
        check("stall_accepted", sent, 2);
        ready_i = 1'b1;
        for (int c = 0; c < 20 && sent < 6; c++) begin
            @(negedge clk_i);
            acc = ready_o;
            tick();
            if (acc) begin
                sent++;
                data_i = {24'h000000, W'(16 + sent)};
            end
        end
        valid_i = 1'b0;
        idle(5);

        // Simultaneous up and down leaves the target alone.
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send(24'h000010, 24'h000020);
        idle(4);
        check("gain_hold", gain_o, 128);

        // From reset, nine down pulses clamp the target at zero.
        reset_i = 1'b1;
        idle(2);
        reset_i = 1'b0;
        tick();
        repeat (9) pulse(1'b0, 1'b1);
        for (int i = 0; i < 70; i++) send(W'(i * 12345), 24'h7FFFFF);
        idle(4);
        check("gain_zero", gain_o, 0);
        send(24'h123456, 24'h7FFFFF);
        expect_out("mute", {24'h000000, 24'h000000}, 1'b0, 2);

        // Reset with two beats in flight.
        repeat (2) pulse(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(24'h000400, 24'h000800);
        idle(4);
        check("gain_5", gain_o, 5);
        ready_i = 1'b0;
        send(24'h111111, 24'h222222);
        send(24'h333333, 24'h444444);
        check("inflight_valid", valid_o, 1);
        reset_i = 1'b1;
        #1;
        check("async_valid", valid_o, 0);
        check("async_gain", gain_o, 64);
        check("async_clip", clip_o, 0);
        check("async_data", data_o, 0);
        tick();
        reset_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("no_stale", valid_o, 0);
            tick();
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end

endmodule
